conv_tile_scheduler: RTL and testbench

// - Sequencer for the multi-lane 2D-convolution datapath: walks output tiles of LANES adjacent columns.
// - Per tile it drives the shared X/W read addresses, per-lane MAC init/valid strobes, waits for MAC drain,

---
 rtl/conv_pkg.sv | 35 +++
 rtl/conv_tap_counter.sv | 39 +++
 rtl/conv_tile_scheduler.sv | 177 +++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution tile scheduler.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    INIT,
    FEED,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // This clog2 never returns 0, so degenerate parameters still give legal vectors.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int k_bits(input int maxk);
    return clog2w(maxk + 1);
  endfunction

  function automatic int x_addr_bits(input int rows, input int cols);
    return clog2w(rows * cols);
  endfunction

  function automatic int w_addr_bits(input int maxk);
    return clog2w(maxk * maxk);
  endfunction

  function automatic int lane_bits(input int lanes);
    return clog2w(lanes);
  endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Kernel tap walker: j runs fastest and wraps at K-1 into i.
// The last flag marks tap (K-1, K-1).
module conv_tap_counter
  import conv_pkg::*;
#(
  parameter int MAXK = 9,
  localparam int K_BITS = k_bits(MAXK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [K_BITS-1:0] k,
  output logic [K_BITS-1:0] i,
  output logic [K_BITS-1:0] j,
  output logic              last
);

  logic [K_BITS-1:0] k_m1;

  assign k_m1 = k - K_BITS'(1);
  assign last = (i == k_m1) && (j == k_m1);

  // Advance one tap per enabled cycle; clear parks the counter at (0,0).
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      i <= '0;
      j <= '0;
    end else if (en) begin
      if (j == k_m1) begin
        j <= '0;
        i <= (i == k_m1) ? '0 : i + K_BITS'(1);
      end else begin
        j <= j + K_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for the multi-lane convolution datapath.
// For each output tile of LANES adjacent columns, the sequence is:
//   - walk the K*K kernel taps;
//   - wait for the MAC pipes to drain;
//   - hand the active lane results to the output FIFO one at a time.
module conv_tile_scheduler
  import conv_pkg::*;
#(
  parameter int R       = 16,
  parameter int C       = 17,
  parameter int MAXK    = 9,
  parameter int LANES   = 4,
  parameter int MAC_LAT = 4,
  localparam int K_BITS      = k_bits(MAXK),
  localparam int X_ADDR_BITS = x_addr_bits(R, C),
  localparam int W_ADDR_BITS = w_addr_bits(MAXK),
  localparam int LANE_BITS   = lane_bits(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [K_BITS-1:0]      k_in,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [X_ADDR_BITS-1:0] x_addr,
  output logic [W_ADDR_BITS-1:0] w_addr,
  output logic [LANES-1:0]       lane_init,
  output logic [LANES-1:0]       lane_valid,
  output logic [LANE_BITS-1:0]   out_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int RW = clog2w(R + 1);
  localparam int CW = clog2w(C + LANES + 1);

  state_t                 state, state_nxt;
  logic [K_BITS-1:0]      k_q;
  logic [RW-1:0]          r_q;
  logic [CW-1:0]          c_q;
  logic [LANE_BITS-1:0]   idx_q;
  logic                   cfg_err_q;
  logic [MAC_LAT-1:0]     vld_pipe;
  logic [X_ADDR_BITS-1:0] x_addr_q, x_addr_cmb;
  logic [W_ADDR_BITS-1:0] w_addr_q, w_addr_cmb;

  logic [K_BITS-1:0] tap_i, tap_j;
  logic              tap_last;

  logic [31:0]      r_out, c_out, nact;
  logic [LANES-1:0] mask;
  logic             k_ok, accept, presenting, last_lane, row_wrap, final_tile;

  conv_tap_counter #(.MAXK(MAXK)) u_tap (
    .clk   (clk),
    .reset (reset),
    .clear ((state == IDLE) || (state == SETUP)),
    .en    (state == FEED),
    .k     (k_q),
    .i     (tap_i),
    .j     (tap_j),
    .last  (tap_last)
  );

  // A kernel must be non-empty and must fit in the configured maximum and in the image.
  assign k_ok = (k_in != '0) && (32'(k_in) <= 32'(MAXK)) &&
                (32'(k_in) <= 32'(R)) && (32'(k_in) <= 32'(C));
  assign accept = (state == IDLE) && start && k_ok;

  // Output geometry. Everything is compared in 32 bits so no intermediate value truncates.
  assign r_out = 32'(R) - 32'(k_q) + 32'd1;
  assign c_out = 32'(C) - 32'(k_q) + 32'd1;

  // A lane is active while its column still lies inside the output width.
  for (genvar l = 0; l < LANES; l++) begin : g_mask
    assign mask[l] = (32'(c_q) + 32'(l)) < c_out;
  end

  // Count the active lanes in the current tile.
  always_comb begin
    nact = '0;
    for (int l = 0; l < LANES; l++) nact = nact + 32'(mask[l]);
  end

  assign last_lane  = (32'(idx_q) == nact - 32'd1);
  assign row_wrap   = (32'(c_q) + 32'(LANES)) >= c_out;
  assign final_tile = row_wrap && (32'(r_q) == r_out - 32'd1);

  // Lane-0 addresses follow the tap counters directly while a tile is being read.
  assign x_addr_cmb = X_ADDR_BITS'((32'(r_q) + 32'(tap_i)) * 32'(C) + 32'(c_q) + 32'(tap_j));
  assign w_addr_cmb = W_ADDR_BITS'(32'(tap_i) * 32'(k_q) + 32'(tap_j));
  assign presenting = (state == SETUP) || (state == INIT) || (state == FEED);

  assign x_addr     = presenting ? x_addr_cmb : x_addr_q;
  assign w_addr     = presenting ? w_addr_cmb : w_addr_q;
  assign lane_init  = (state == INIT) ? mask : '0;
  assign lane_valid = (state == FEED) ? mask : '0;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign cfg_err    = cfg_err_q;
  assign out_valid  = (state == WRITE);
  assign out_sel    = idx_q;
  assign out_last   = out_valid && final_tile && last_lane;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. Once a run has left IDLE, start is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: state_nxt = INIT;
      INIT:  state_nxt = FEED;
      FEED:  if (tap_last) state_nxt = DRAIN;
      DRAIN: if (vld_pipe[MAC_LAT-1]) state_nxt = WRITE;
      WRITE: if (out_ready && last_lane) state_nxt = final_tile ? DONE : SETUP;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers:
  //   - config latch, tile and lane counters;
  //   - the drain pipe;
  //   - the address hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
      vld_pipe  <= '0;
      x_addr_q  <= '0;
      w_addr_q  <= '0;
    end else begin
      cfg_err_q <= (state == IDLE) && start && !k_ok;

      if (accept) begin
        k_q   <= k_in;
        r_q   <= '0;
        c_q   <= '0;
        idx_q <= '0;
      end

      if (presenting) begin
        x_addr_q <= x_addr_cmb;
        w_addr_q <= w_addr_cmb;
      end

      // The last tap enters the pipe. WRITE begins after exactly MAC_LAT DRAIN cycles.
      vld_pipe[0] <= (state == FEED) && tap_last;
      for (int s = 1; s < MAC_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];

      if ((state == WRITE) && out_ready) begin
        if (last_lane) begin
          idx_q <= '0;
          if (row_wrap) begin
            c_q <= '0;
            r_q <= r_q + RW'(1);
          end else begin
            c_q <= c_q + CW'(LANES);
          end
        end else begin
          idx_q <= idx_q + LANE_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler with R=16, C=17, MAXK=9, LANES=4, MAC_LAT=4.
module tb_conv_tile_scheduler;

  localparam int R = 16, C = 17, MAXK = 9, LANES = 4, MAC_LAT = 4;

  logic       clk = 0;
  logic       reset = 1;
  logic       start = 0;
  logic [3:0] k_in = '0;
  logic       busy, done, cfg_err;
  logic [8:0] x_addr;
  logic [6:0] w_addr;
  logic [3:0] lane_init, lane_valid;
  logic [1:0] out_sel;
  logic       out_valid, out_last;
  logic       out_ready = 1;

  conv_tile_scheduler #(.R(R), .C(C), .MAXK(MAXK), .LANES(LANES), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .k_in(k_in), .busy(busy), .done(done),
    .cfg_err(cfg_err), .x_addr(x_addr), .w_addr(w_addr), .lane_init(lane_init),
    .lane_valid(lane_valid), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int w; int m; } feed_t;
  typedef struct { int sel; int last; } beat_t;

  feed_t feed_q[$];
  beat_t out_q[$];
  int    init_q[$];

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0;
  bit mon_en = 1;
  bit expect_done = 0;
  logic [3:0] prev_init = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Build the reference sequence for one run from the tile geometry alone.
  task automatic build_model(input int k);
    int rout, cout, nact;
    rout = R - k + 1;
    cout = C - k + 1;
    for (int r = 0; r < rout; r++)
      for (int c = 0; c < cout; c += LANES) begin
        nact = (cout - c < LANES) ? cout - c : LANES;
        init_q.push_back((1 << nact) - 1);
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            feed_q.push_back('{x: (r + i) * C + c + j, w: i * k + j, m: (1 << nact) - 1});
        for (int l = 0; l < nact; l++)
          out_q.push_back('{sel: l, last: (r == rout - 1 && c + LANES >= cout && l == nact - 1)});
      end
  endtask

  // Monitor: samples on the falling edge and compares against the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && mon_en) begin
      if (expect_done) begin
        chk("done_after_last", done, 1);
        expect_done = 0;
      end
      if (prev_init != 0) chk("init_to_valid", lane_valid, prev_init);
      if (lane_init != 0) begin
        if (init_q.size() == 0) chk("init_unexpected", lane_init, 0);
        else chk("lane_init", lane_init, init_q.pop_front());
      end
      if (lane_valid != 0) begin
        if (feed_q.size() == 0) chk("feed_unexpected", lane_valid, 0);
        else begin
          feed_t f;
          f = feed_q.pop_front();
          chk("x_addr", x_addr, f.x);
          chk("w_addr", w_addr, f.w);
          chk("lane_valid", lane_valid, f.m);
        end
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) chk("beat_unexpected", out_valid, 0);
        else begin
          beat_t b;
          b = out_q.pop_front();
          chk("out_sel", out_sel, b.sel);
          chk("out_last", out_last, b.last);
          if (out_last) expect_done = 1;
        end
      end
    end
    prev_init = lane_init;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one convolution. Optional stress: backpressure at out_sel==2, or a stray start during FEED.
  task automatic run_conv(input int k, input bit bp, input bit stray);
    int d0, cyc;
    bit bp_pend, st_pend;
    bp_pend = bp;
    st_pend = stray;
    d0 = done_cnt;
    build_model(k);
    tick();
    start = 1;
    k_in = 4'(k);
    tick();
    start = 0;
    chk("busy_after_start", busy, 1);
    for (cyc = 0; cyc < 6000; cyc++) begin
      if (start) start = 0;
      if (done) break;
      if (st_pend && lane_valid != 0) begin
        start = 1;
        k_in = 4'd5;
        st_pend = 0;
      end
      if (bp_pend && out_valid && out_sel == 2) begin
        out_ready = 0;
        bp_pend = 0;
        repeat (5) begin
          tick();
          chk("bp_valid", out_valid, 1);
          chk("bp_sel", out_sel, 2);
        end
        out_ready = 1;
      end
      tick();
    end
    chk("run_done_seen", done, 1);
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("queues_drained", feed_q.size() + out_q.size() + init_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_x"}, x_addr, 0);
    chk({tag, "_w"}, w_addr, 0);
    chk({tag, "_init"}, lane_init, 0);
    chk({tag, "_valid"}, lane_valid, 0);
    chk({tag, "_oval"}, out_valid, 0);
    chk({tag, "_osel"}, out_sel, 0);
    chk({tag, "_olast"}, out_last, 0);
  endtask

  initial begin
    int d0, cyc;
    repeat (3) tick();
    check_idle_outputs("rst");
    chk("rst_cfg_err", cfg_err, 0);
    reset = 0;
    tick();

    // Rejected configurations.
    for (int t = 0; t < 2; t++) begin
      start = 1;
      k_in = (t == 0) ? 4'd0 : 4'd10;
      tick();
      start = 0;
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      tick();
      chk("cfg_err_clear", cfg_err, 0);
      chk("cfg_err_idle", busy, 0);
    end

    run_conv(9, 1, 0);
    run_conv(3, 0, 1);
    run_conv(1, 0, 0);

    // Abort mid-FEED: reset must return everything to idle with no done.
    mon_en = 0;
    d0 = done_cnt;
    tick();
    start = 1;
    k_in = 4'd3;
    tick();
    start = 0;
    for (cyc = 0; cyc < 50 && lane_valid == 0; cyc++) tick();
    chk("abort_reached_feed", (lane_valid != 0), 1);
    reset = 1;
    tick();
    check_idle_outputs("abort");
    reset = 0;
    repeat (20) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    feed_q.delete();
    out_q.delete();
    init_q.delete();
    prev_init = '0;
    mon_en = 1;

    run_conv(3, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
